// File: rtl/mod_sram_arb_if.sv
// rtl/mod_sram_arb_if.sv - requester and SRAM-controller bundle for mod_sram_arb
interface mod_sram_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          v_req;
    logic [AW-1:0] v_addr;
    logic          i_done;
    logic          d_done;
    logic          v_done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdy;

    // Arbiter side: takes requests and controller responses.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, v_req, v_addr,
        output i_done, d_done, v_done, rdata, err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_rdy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, v_req, v_addr,
        input  i_done, d_done, v_done, rdata, err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_rdy
    );
endinterface

// File: rtl/mod_sram_arb.sv
// rtl/mod_sram_arb.sv - shares one SRAM controller port between I-fetch, D-access and VGA fetch
module mod_sram_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int VGA_MAX = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    mod_sram_arb_if.slave  bus
);
    localparam int CW = $clog2(VGA_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_I, OWN_D, OWN_V} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [7:0]    timer_q, timer_d;
    logic [CW-1:0] vga_cnt_q, vga_cnt_d;
    logic          last_d_q, last_d_d;

    logic cpu_pend;
    logic v_win;
    logic pick_d;

    always_comb begin
        cpu_pend  = bus.i_req | bus.d_req;
        v_win     = bus.v_req & (~cpu_pend | (vga_cnt_q < CW'(VGA_MAX)));
        // With both CPU ports waiting, the one not served last goes next.
        pick_d    = bus.d_req & (~bus.i_req | ~last_d_q);

        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timer_d   = timer_q;
        vga_cnt_d = vga_cnt_q;
        last_d_d  = last_d_q;

        case (state_q)
            S_IDLE: begin
                timer_d = 8'd0;
                err_d   = 1'b0;
                if (v_win) begin
                    owner_d = OWN_V;
                    addr_d  = bus.v_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = S_BUSY;
                    if (!cpu_pend)
                        vga_cnt_d = '0;
                    else if (vga_cnt_q != CW'(VGA_MAX))
                        vga_cnt_d = vga_cnt_q + 1'b1;
                end else if (cpu_pend) begin
                    vga_cnt_d = '0;
                    state_d   = S_BUSY;
                    if (pick_d) begin
                        owner_d  = OWN_D;
                        addr_d   = bus.d_addr;
                        we_d     = bus.d_we;
                        wdata_d  = bus.d_wdata;
                        last_d_d = 1'b1;
                    end else begin
                        owner_d  = OWN_I;
                        addr_d   = bus.i_addr;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        last_d_d = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                // A response arriving on the abort cycle still counts as good.
                if (bus.mem_rdy) begin
                    rdata_d = bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_I;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timer_q   <= 8'd0;
            vga_cnt_q <= '0;
            last_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            vga_cnt_q <= vga_cnt_d;
            last_d_q  <= last_d_d;
        end
    end

    assign bus.mem_req   = (state_q == S_BUSY);
    assign bus.mem_we    = (state_q == S_BUSY) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_done    = (state_q == S_RESP) & (owner_q == OWN_I);
    assign bus.d_done    = (state_q == S_RESP) & (owner_q == OWN_D);
    assign bus.v_done    = (state_q == S_RESP) & (owner_q == OWN_V);
    assign bus.rdata     = rdata_q;
    assign bus.err       = (state_q == S_RESP) & err_q;
endmodule

// File: tb/tb_mod_sram_arb.sv
// tb/tb_mod_sram_arb.sv - scoreboard bench for mod_sram_arb
module tb_mod_sram_arb;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int VGA_MAX = 4;
    localparam int TIMEOUT = 8;
    localparam logic [DW-1:0] RD_XOR = 32'h5A5A_0000;

    localparam int W_I = 0, W_D = 1, W_V = 2, W_NONE = 3;

    typedef struct {
        int            who;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mod_sram_arb_if #(.AW(AW), .DW(DW)) bus();

    mod_sram_arb #(.AW(AW), .DW(DW), .VGA_MAX(VGA_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    bit   rdy_en = 1'b1;
    int   rdy_lat = 1;
    int   busy_cnt = 0;
    int   rdy_cyc = -1;
    int   req_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: answers rdy_lat cycles into each request with addr^RD_XOR.
    always @(negedge clk) begin
        if (bus.mem_req)
            req_cycles <= req_cycles + 1;
        if (bus.mem_req && rdy_en && !bus.mem_rdy) begin
            busy_cnt <= busy_cnt + 1;
            if (busy_cnt + 1 >= rdy_lat) begin
                bus.mem_rdy   <= 1'b1;
                bus.mem_rdata <= bus.mem_addr ^ RD_XOR;
                rdy_cyc       <= cyc;
            end
        end else begin
            bus.mem_rdy <= 1'b0;
            busy_cnt    <= 0;
        end
    end

    task automatic wait_done(input int budget, output int who, output logic [DW-1:0] rd,
                             output logic er, output int at, output bit multi);
        int n;
        who = W_NONE; rd = '0; er = 1'b0; at = -1; multi = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            n = int'(bus.i_done) + int'(bus.d_done) + int'(bus.v_done);
            if (n != 0) begin
                multi = (n > 1);
                who   = bus.i_done ? W_I : (bus.d_done ? W_D : W_V);
                rd    = bus.rdata;
                er    = bus.err;
                at    = cyc;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.v_req = 1'b0; bus.v_addr = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.i_done, bus.d_done, bus.v_done, bus.err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.mem_req, bus.mem_we, bus.i_done, bus.d_done, bus.v_done, bus.err});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.rdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        int who, at, c0; logic [DW-1:0] rd; logic er; bit multi; exp_t e;
        rdy_lat = 2;
        @(negedge clk);
        bus.d_addr = 32'h100; bus.d_we = 1'b0; bus.d_req = 1'b1;
        c0 = cyc;
        sb.push_back('{W_D, 32'h100 ^ RD_XOR, 1'b0});
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1 || cyc != c0 + 1) begin
            errors++;
            $display("FAIL read_req_latency: got mem_req=%b cycle=%0d expected 1 at %0d", bus.mem_req, cyc, c0 + 1);
        end
        checks++;
        if (bus.mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL read_addr: got %h expected 00000100", bus.mem_addr);
        end
        wait_done(20, who, rd, er, at, multi);
        bus.d_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (who != e.who || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL read_done: got who=%0d rdata=%h err=%b expected who=%0d rdata=%h err=%b",
                     who, rd, er, e.who, e.rdata, e.err);
        end
        checks++;
        if (at != rdy_cyc + 1) begin
            errors++;
            $display("FAIL read_done_latency: got cycle %0d expected %0d", at, rdy_cyc + 1);
        end
    endtask

    task automatic run_grants(input string name, input int n);
        int who, at; logic [DW-1:0] rd; logic er; bit multi; exp_t e;
        for (int k = 0; k < n; k++) begin
            wait_done(30, who, rd, er, at, multi);
            e = sb.pop_front();
            checks++;
            if (who != e.who || rd !== e.rdata || er !== e.err) begin
                errors++;
                $display("FAIL %s_grant%0d: got who=%0d rdata=%h err=%b expected who=%0d rdata=%h err=%b",
                         name, k, who, rd, er, e.who, e.rdata, e.err);
            end
            checks++;
            if (multi) begin
                errors++;
                $display("FAIL %s_single_done%0d: got multiple dones expected one", name, k);
            end
            if (who == W_NONE) begin
                sb.delete();
                break;
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.v_req = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        rdy_lat = 1;
        bus.i_addr = 32'h1000; bus.d_addr = 32'h104; bus.d_we = 1'b0;
        for (int k = 0; k < 4; k++)
            sb.push_back((k % 2 == 0) ? '{W_D, 32'h104 ^ RD_XOR, 1'b0} : '{W_I, 32'h1000 ^ RD_XOR, 1'b0});
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        run_grants("rr", 4);
    endtask

    task automatic test_vga_cap();
        exp_t ev, ed, ei;
        do_reset();
        rdy_lat = 1;
        bus.v_addr = 32'h8000; bus.i_addr = 32'h1040; bus.d_addr = 32'h2040; bus.d_we = 1'b0;
        ev = '{W_V, 32'h8000 ^ RD_XOR, 1'b0};
        ed = '{W_D, 32'h2040 ^ RD_XOR, 1'b0};
        ei = '{W_I, 32'h1040 ^ RD_XOR, 1'b0};
        for (int k = 0; k < 10; k++)
            sb.push_back((k == 4) ? ed : ((k == 9) ? ei : ev));
        bus.v_req = 1'b1; bus.i_req = 1'b1; bus.d_req = 1'b1;
        run_grants("vga", 10);
    endtask

    task automatic test_write();
        int busy; bit seen_done; bit bad; exp_t e;
        rdy_lat = 3;
        busy = 0; seen_done = 1'b0; bad = 1'b0;
        @(negedge clk);
        bus.d_addr = 32'h2000; bus.d_we = 1'b1; bus.d_wdata = 32'hDEADBEEF; bus.d_req = 1'b1;
        sb.push_back('{W_D, 32'h2000 ^ RD_XOR, 1'b0});
        for (int k = 0; k < 20 && !seen_done; k++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                busy++;
                if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hDEADBEEF || bus.mem_addr !== 32'h2000)
                    bad = 1'b1;
            end
            if (bus.i_done || bus.d_done || bus.v_done) begin
                seen_done = 1'b1;
                bus.d_req = 1'b0;
                e = sb.pop_front();
                checks++;
                if (bus.d_done !== 1'b1 || bus.err !== e.err || bus.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL write_done: got d_done=%b err=%b rdata=%h expected 1 %b %h",
                             bus.d_done, bus.err, bus.rdata, e.err, e.rdata);
                end
            end
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL write_timeout: got no done expected d_done");
        end
        checks++;
        if (bad || busy != 3) begin
            errors++;
            $display("FAIL write_bus_stable: got bad=%0d busy_cycles=%0d expected 0 and 3", bad, busy);
        end
    endtask

    task automatic test_timeout();
        int who, at, r0; logic [DW-1:0] rd; logic er; bit multi; exp_t e;
        rdy_en = 1'b0;
        @(negedge clk);
        r0 = req_cycles;
        bus.i_addr = 32'h3000; bus.i_req = 1'b1;
        sb.push_back('{W_I, 32'h0, 1'b1});
        wait_done(40, who, rd, er, at, multi);
        bus.i_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (who != e.who || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL timeout_done: got who=%0d rdata=%h err=%b expected who=%0d rdata=%h err=%b",
                     who, rd, er, e.who, e.rdata, e.err);
        end
        checks++;
        if (req_cycles - r0 != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_req_cycles: got %0d expected %0d", req_cycles - r0, TIMEOUT);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_after: got err=%b rdata=%h expected 0 and 0", bus.err, bus.rdata);
        end
        rdy_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int who, at; logic [DW-1:0] rd; logic er; bit multi; bit got;
        rdy_lat = 1;
        bus.i_addr = 32'h4000; bus.d_addr = 32'h5000; bus.d_we = 1'b0;
        @(negedge clk);
        bus.i_req = 1'b1;
        wait_done(20, who, rd, er, at, multi);
        bus.i_req = 1'b0;
        rdy_en = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = bus.mem_req;
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.mem_req, bus.i_done, bus.d_done, bus.v_done} !== 4'b0 || !got) begin
            errors++;
            $display("FAIL midreset_outputs: got mem_req=%b dones=%b%b%b busy_seen=%0d expected 0 000 1",
                     bus.mem_req, bus.i_done, bus.d_done, bus.v_done, got);
        end
        bus.d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rdy_en = 1'b1;
        sb.push_back('{W_D, 32'h5000 ^ RD_XOR, 1'b0});
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        run_grants("midreset", 1);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_vga_cap();
        test_write();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
